keypad_emulator: RTL and testbench

- Drives the keypad side of the 4x4 matrix interface used by the keypad scanner: it receives the scanner's active-low ROW drive and returns active-low COLUMN sense lines.
- Key codes are queued through a valid/ready FIFO. Each key is "pressed" for a programmable hold time, then released for a programmable gap.
- Used on-board for self-test and in simulation as the scanner's bus-functional partner.

---
 rtl/keypad_emulator.sv | 167 ++++++++++++++++
 tb/tb_keypad_emulator.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_emulator.sv
// Keypad-side partner for the 4x4 matrix scanner: queued key codes are "pressed" for a hold time, then released for a gap.
// Optional contact-bounce modelling during the start of each press is enabled by defining KEYPAD_EMU_BOUNCE_EN.
module keypad_emulator #(
  parameter logic [23:0] HOLD_CYCLES = 24'd1000000,
  parameter logic [23:0] GAP_CYCLES  = 24'd1000000,
  parameter int          FIFO_DEPTH  = 4,
  parameter int          FIFO_AW     = 2
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic               key_valid,
  input  logic [3:0]         key_code,
  output logic               key_ready,
  input  logic [3:0]         ROW,
  output logic [3:0]         COLUMN,
  output logic               busy,
  output logic [3:0]         active_key,
  output logic [FIFO_AW:0]   fifo_count
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_HOLD,
    S_GAP
  } state_e;

  localparam logic [23:0]      HOLD_LEN = (HOLD_CYCLES == 24'd0) ? 24'd1 : HOLD_CYCLES;
  localparam logic [23:0]      GAP_LEN  = (GAP_CYCLES == 24'd0) ? 24'd1 : GAP_CYCLES;
  localparam logic [FIFO_AW:0] DEPTH_C  = (FIFO_AW + 1)'(FIFO_DEPTH);

  state_e               state_q, state_d;
  logic [23:0]          cnt_q, cnt_d;
  logic [3:0]           active_key_q, active_key_d;
  logic [FIFO_AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [FIFO_AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [FIFO_AW:0]     count_q, count_d;
  logic                 key_ready_q, key_ready_d;
  logic [3:0]           mem [FIFO_DEPTH];

  logic                 push;
  logic                 pop;
  logic [1:0]           key_row;
  logic [1:0]           key_col;
  logic                 press_en;

  assign push = key_valid && key_ready_q;
  assign pop  = (state_q == S_IDLE) && (count_q != '0);

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned and infers a latch.
    state_d      = state_q;
    cnt_d        = cnt_q;
    active_key_d = active_key_q;
    rd_ptr_d     = rd_ptr_q;
    wr_ptr_d     = wr_ptr_q;

    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;

    // Push and pop on the same edge cancel in the count; pointers still advance.
    count_d     = count_q + (FIFO_AW + 1)'(push) - (FIFO_AW + 1)'(pop);
    key_ready_d = (count_d != DEPTH_C);

    case (state_q)
      S_IDLE: begin
        if (pop) begin
          active_key_d = mem[rd_ptr_q];
          cnt_d        = HOLD_LEN;
          state_d      = S_HOLD;
        end
      end
      S_HOLD: begin
        if (cnt_q == 24'd1) begin
          cnt_d   = GAP_LEN;
          state_d = S_GAP;
        end else begin
          cnt_d = cnt_q - 24'd1;
        end
      end
      S_GAP: begin
        if (cnt_q == 24'd1) begin
          cnt_d   = 24'd0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - 24'd1;
        end
      end
      default: begin
        cnt_d   = 24'd0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!RESET) begin
      state_q      <= S_IDLE;
      cnt_q        <= 24'd0;
      active_key_q <= 4'h0;
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      count_q      <= '0;
      key_ready_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      active_key_q <= active_key_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      count_q      <= count_d;
      key_ready_q  <= key_ready_d;
    end
  end

  // NOTE: the key storage is deliberately not reset; emptying the queue is done by resetting the pointers and count.
  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr_q] <= key_code;
  end

  // Matrix position of the active key, matching the scanner's decode table.
  always_comb begin
    key_row = 2'd0;
    key_col = 2'd0;
    case (active_key_q)
      4'hF: begin key_row = 2'd0; key_col = 2'd0; end
      4'hE: begin key_row = 2'd0; key_col = 2'd1; end
      4'hD: begin key_row = 2'd0; key_col = 2'd2; end
      4'hC: begin key_row = 2'd0; key_col = 2'd3; end
      4'hB: begin key_row = 2'd1; key_col = 2'd0; end
      4'h3: begin key_row = 2'd1; key_col = 2'd1; end
      4'h6: begin key_row = 2'd1; key_col = 2'd2; end
      4'h9: begin key_row = 2'd1; key_col = 2'd3; end
      4'hA: begin key_row = 2'd2; key_col = 2'd0; end
      4'h2: begin key_row = 2'd2; key_col = 2'd1; end
      4'h5: begin key_row = 2'd2; key_col = 2'd2; end
      4'h8: begin key_row = 2'd2; key_col = 2'd3; end
      4'h0: begin key_row = 2'd3; key_col = 2'd0; end
      4'h1: begin key_row = 2'd3; key_col = 2'd1; end
      4'h4: begin key_row = 2'd3; key_col = 2'd2; end
      4'h7: begin key_row = 2'd3; key_col = 2'd3; end
      default: begin key_row = 2'd0; key_col = 2'd0; end
    endcase
  end

`ifdef KEYPAD_EMU_BOUNCE_EN
  logic [23:0] hold_elapsed;

  // Elapsed hold cycles: 0 on the first HOLD cycle. Bit 3 toggles the contact every 8 cycles for the first 64.
  assign hold_elapsed = HOLD_LEN - cnt_q;
  assign press_en     = (hold_elapsed >= 24'd64) || !hold_elapsed[3];
`else
  assign press_en = 1'b1;
`endif

  // Only the active key's own row selects the press; other low rows are don't-care.
  always_comb begin
    COLUMN = 4'b1111;
    if ((state_q == S_HOLD) && press_en) COLUMN[key_col] = ROW[key_row];
  end

  assign key_ready  = key_ready_q;
  assign busy       = (state_q != S_IDLE) || (count_q != '0);
  assign active_key = active_key_q;
  assign fifo_count = count_q;

endmodule

// File: tb/tb_keypad_emulator.sv
// Directed and randomized checks of keypad_emulator against a timeline model of queued key presses.
module tb_keypad_emulator;

  localparam int H     = 10;
  localparam int G     = 5;
  localparam int DEPTH = 4;
  localparam int AW    = 2;

  logic          CLK;
  logic          RESET;
  logic          key_valid;
  logic [3:0]    key_code;
  logic          key_ready;
  logic [3:0]    ROW;
  logic [3:0]    COLUMN;
  logic          busy;
  logic [3:0]    active_key;
  logic [AW:0]   fifo_count;

  keypad_emulator #(
    .HOLD_CYCLES (24'(H)),
    .GAP_CYCLES  (24'(G)),
    .FIFO_DEPTH  (DEPTH),
    .FIFO_AW     (AW)
  ) dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .key_valid  (key_valid),
    .key_code   (key_code),
    .key_ready  (key_ready),
    .ROW        (ROW),
    .COLUMN     (COLUMN),
    .busy       (busy),
    .active_key (active_key),
    .fifo_count (fifo_count)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_pass   = 0;

  // Keypad layout, row-major: entry r*4+c is the key at row r, column c.
  logic [3:0] layout [16] = '{4'hF, 4'hE, 4'hD, 4'hC,
                              4'hB, 4'h3, 4'h6, 4'h9,
                              4'hA, 4'h2, 4'h5, 4'h8,
                              4'h0, 4'h1, 4'h4, 4'h7};

  // Model: a key is "running" for H+G cycles after its pop; t counts cycles since the pop.
  logic [3:0] q [$];
  bit         m_run;
  int         m_t;
  logic [3:0] m_active;
  bit         m_ready;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic model_reset();
    q.delete();
    m_run    = 1'b0;
    m_t      = 0;
    m_active = 4'h0;
    m_ready  = 1'b0;
  endtask

  function automatic logic [3:0] exp_col(input logic [3:0] row);
    logic [3:0] col;
    bit         pressed;
    col     = 4'b1111;
    pressed = m_run && (m_t < H);
`ifdef KEYPAD_EMU_BOUNCE_EN
    if (m_t < 64 && ((m_t / 8) % 2 == 1)) pressed = 1'b0;
`endif
    if (pressed) begin
      for (int i = 0; i < 16; i++) begin
        if (layout[i] == m_active) col[i % 4] = row[i / 4];
      end
    end
    return col;
  endfunction

  task automatic check_all();
    check("key_ready", 8'(key_ready), 8'(m_ready));
    check("fifo_count", 8'(fifo_count), 8'(q.size()));
    check("busy", 8'(busy), 8'(m_run || (q.size() != 0)));
    check("active_key", 8'(active_key), 8'(m_active));
    check("column", 8'(COLUMN), 8'(exp_col(ROW)));
  endtask

  task automatic check_col();
    #1;
    check("column_row", 8'(COLUMN), 8'(exp_col(ROW)));
  endtask

  task automatic step();
    bit do_pop;
    bit do_push;
    @(posedge CLK);
    if (!RESET) begin
      model_reset();
    end else begin
      do_pop  = !m_run && (q.size() != 0);
      do_push = key_valid && m_ready;
      if (m_run) begin
        m_t++;
        if (m_t == H + G) m_run = 1'b0;
      end
      if (do_pop) begin
        m_active = q.pop_front();
        m_run    = 1'b1;
        m_t      = 0;
      end
      if (do_push) q.push_back(key_code);
      m_ready = (q.size() != DEPTH);
    end
    #1;
    check_all();
  endtask

  task automatic drain();
    for (int i = 0; i < 400 && (m_run || q.size() != 0); i++) step();
    step();
    check("drained_busy", 8'(busy), 8'h00);
  endtask

  initial begin
    int hits;
    logic [3:0] codes [6] = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6};

    // Reset with key_valid held high.
    RESET     = 1'b0;
    key_valid = 1'b1;
    key_code  = 4'h3;
    ROW       = 4'b0000;
    model_reset();
    #2;
    check("rst_column", 8'(COLUMN), 8'h0F);
    check("rst_key_ready", 8'(key_ready), 8'h00);
    check("rst_fifo_count", 8'(fifo_count), 8'h00);
    check("rst_busy", 8'(busy), 8'h00);
    repeat (2) step();
    RESET = 1'b1;
    step();
    check("ready_after_release", 8'(key_ready), 8'h01);
    key_valid = 1'b0;

    // Single key 0x5 on row 2 / column 2.
    ROW       = 4'b1011;
    key_code  = 4'h5;
    key_valid = 1'b1;
    step();
    key_valid = 1'b0;
    for (int i = 0; i < H; i++) begin
      step();
      check("single_pressed", 8'(COLUMN), 8'h0B);
      if (i == 4) begin
        ROW = 4'b1110;
        #1;
        check("single_wrong_row", 8'(COLUMN), 8'h0F);
        ROW = 4'b1011;
      end
    end
    step();
    check("single_released", 8'(COLUMN), 8'h0F);
    drain();

    // Full map sweep: each key, each active-low row value.
    for (int k = 0; k < 16; k++) begin
      ROW       = 4'b1111;
      key_code  = 4'(k);
      key_valid = 1'b1;
      step();
      key_valid = 1'b0;
      step();
      hits = 0;
      for (int r = 0; r < 4; r++) begin
        ROW    = 4'b1111;
        ROW[r] = 1'b0;
        check_col();
        if (COLUMN != 4'b1111) hits++;
        if (k == 7 && r == 3) check("key7_column", 8'(COLUMN), 8'h07);
      end
      check("sweep_one_hit", 8'(hits), 8'h01);
      drain();
    end

    // FIFO full: six back-to-back pushes, the second of which coincides with the first pop.
    ROW = 4'b0000;
    for (int i = 0; i < 6; i++) begin
      key_code  = codes[i];
      key_valid = 1'b1;
      step();
      if (i == 1) check("pushpop_count", 8'(fifo_count), 8'h01);
    end
    check("full_ready", 8'(key_ready), 8'h00);
    check("full_count", 8'(fifo_count), 8'h04);
    for (int i = 0; i < 100 && q.size() != 0 && q[q.size()-1] != 4'h6; i++) step();
    key_valid = 1'b0;
    check("sixth_accepted", 8'(q[q.size()-1]), 8'h06);
    drain();
    check("last_emitted", 8'(active_key), 8'h06);

    // Randomized traffic with random row drive.
    for (int i = 0; i < 600; i++) begin
      key_valid = ($urandom_range(0, 3) == 0);
      key_code  = 4'($urandom);
      ROW       = 4'($urandom);
      step();
    end
    key_valid = 1'b0;
    drain();

    // Reset in the middle of holding 0xD with further keys queued.
    ROW       = 4'b1110;
    key_valid = 1'b1;
    key_code  = 4'hD;
    step();
    key_code  = 4'h1;
    step();
    key_code  = 4'h2;
    step();
    key_code  = 4'h3;
    step();
    key_valid = 1'b0;
    step();
    check("mid_hold_pressed", 8'(COLUMN), 8'h0B);
    #2;
    RESET = 1'b0;
    model_reset();
    #1;
    check("async_column", 8'(COLUMN), 8'h0F);
    check("async_busy", 8'(busy), 8'h00);
    check("async_count", 8'(fifo_count), 8'h00);
    step();
    RESET = 1'b1;
    for (int i = 0; i < 40; i++) begin
      ROW = 4'($urandom);
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
